// File: rtl/png_line_sch_if.sv
// Handshake and status bundle between the pixel source / filter datapath and png_line_sch.
// Ports: frame control (start/abort/cfg), upstream pixel handshake, line-buffer strobes,
//        downstream read stream (valid, pass, col, row_end) and frame status (row, busy, done).
interface png_line_sch_if #(
    parameter int W_WD = 13,
    parameter int H_WD = 13
);
    logic            start_i;
    logic            abort_i;
    logic [W_WD-1:0] cfg_w_i;
    logic [H_WD-1:0] cfg_h_i;
    logic            pix_val_i;
    logic            pix_rdy_o;
    logic            buf_wr_val_o;
    logic            buf_rd_val_o;
    logic            dn_rdy_i;
    logic            dn_val_o;
    logic [1:0]      pass_o;
    logic [W_WD-1:0] col_o;
    logic [H_WD-1:0] row_o;
    logic            first_row_o;
    logic            row_end_o;
    logic            busy_o;
    logic            done_o;

    // Environment side: issues frames, supplies pixels, consumes the read stream.
    modport master (
        output start_i, abort_i, cfg_w_i, cfg_h_i, pix_val_i, dn_rdy_i,
        input  pix_rdy_o, buf_wr_val_o, buf_rd_val_o, dn_val_o, pass_o, col_o,
        input  row_o, first_row_o, row_end_o, busy_o, done_o
    );

    // Scheduler side.
    modport slave (
        input  start_i, abort_i, cfg_w_i, cfg_h_i, pix_val_i, dn_rdy_i,
        output pix_rdy_o, buf_wr_val_o, buf_rd_val_o, dn_val_o, pass_o, col_o,
        output row_o, first_row_o, row_end_o, busy_o, done_o
    );
endinterface

// File: rtl/png_line_sch.sv
// Row scheduler for the PNG filter line buffer: write each row once, read it back three times.
// Latency: per unstalled row w LOAD + 3w PASS + 1 NEXT cycles; read data valid RD_LAT after strobe.
// Backpressure: dn_rdy_i low stalls read issue losslessly; issued reads must be accepted downstream.
// Ports: clk, rstn (async active-low) plus png_line_sch_if.slave carrying all frame, pixel,
//        buffer-strobe and downstream signals.
module png_line_sch #(
    parameter int W_WD   = 13,
    parameter int H_WD   = 13,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rstn,
    png_line_sch_if.slave sch
);
    typedef enum logic [2:0] {IDLE, LOAD, PASS, NEXT, DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W_WD-1:0] r_col;
    logic [W_WD-1:0] r_w;
    logic [H_WD-1:0] r_row;
    logic [H_WD-1:0] r_h;
    logic [1:0]      r_pass;

    // Read-side shift pipe modelling the buffer read latency.
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [RD_LAT-1:0] r_end_pipe;
    logic [1:0]        r_pass_pipe [RD_LAT];
    logic [W_WD-1:0]   r_col_pipe  [RD_LAT];

    logic w_wr;
    logic w_rd;
    logic w_col_last;
    logic w_row_last;
    logic w_pass_last;
    logic w_pipe_empty;
    logic w_done;

    assign w_wr         = (r_state == LOAD) && sch.pix_val_i;
    assign w_rd         = (r_state == PASS) && sch.dn_rdy_i && !sch.abort_i;
    assign w_col_last   = (r_col == (r_w - W_WD'(1)));
    assign w_row_last   = (r_row == (r_h - H_WD'(1)));
    assign w_pass_last  = (r_pass == 2'd2);
    assign w_pipe_empty = (r_vld_pipe == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE: if (sch.start_i) w_state_nxt = LOAD;
            LOAD: if (w_wr && w_col_last) w_state_nxt = PASS;
            PASS: if (w_rd && w_col_last && w_pass_last) w_state_nxt = NEXT;
            NEXT: w_state_nxt = w_row_last ? DONE : LOAD;
            DONE: begin
                // Hold done until the last read has left the pipe.
                if (w_pipe_empty) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (sch.abort_i) begin
            w_state_nxt = IDLE;
            w_done      = 1'b0;
        end
    end

    // Counters and latched frame geometry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col  <= '0;
            r_row  <= '0;
            r_pass <= '0;
            r_w    <= '0;
            r_h    <= '0;
        end else if (sch.abort_i) begin
            r_col  <= '0;
            r_row  <= '0;
            r_pass <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sch.start_i) begin
                        r_col  <= '0;
                        r_row  <= '0;
                        r_pass <= '0;
                        r_w    <= sch.cfg_w_i;
                        r_h    <= sch.cfg_h_i;
                    end
                end
                LOAD: begin
                    if (w_wr) r_col <= w_col_last ? '0 : r_col + W_WD'(1);
                end
                PASS: begin
                    if (w_rd) begin
                        if (w_col_last) begin
                            r_col  <= '0;
                            r_pass <= w_pass_last ? 2'd0 : r_pass + 2'd1;
                        end else begin
                            r_col <= r_col + W_WD'(1);
                        end
                    end
                end
                NEXT: begin
                    r_pass <= '0;
                    if (!w_row_last) r_row <= r_row + H_WD'(1);
                end
                DONE: begin
                    if (w_pipe_empty) r_row <= '0;
                end
                default: ;
            endcase
        end
    end

    // Tags are zeroed on idle cycles so the downstream fields read 0 when dn_val_o is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_pipe <= '0;
            r_end_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pass_pipe[i] <= '0;
                r_col_pipe[i]  <= '0;
            end
        end else if (sch.abort_i) begin
            r_vld_pipe <= '0;
            r_end_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pass_pipe[i] <= '0;
                r_col_pipe[i]  <= '0;
            end
        end else begin
            r_vld_pipe[0]  <= w_rd;
            r_end_pipe[0]  <= w_rd && w_pass_last && w_col_last;
            r_pass_pipe[0] <= w_rd ? r_pass : 2'd0;
            r_col_pipe[0]  <= w_rd ? r_col : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_end_pipe[i]  <= r_end_pipe[i-1];
                r_pass_pipe[i] <= r_pass_pipe[i-1];
                r_col_pipe[i]  <= r_col_pipe[i-1];
            end
        end
    end

    assign sch.pix_rdy_o    = (r_state == LOAD);
    assign sch.buf_wr_val_o = w_wr;
    assign sch.buf_rd_val_o = w_rd;
    assign sch.dn_val_o     = r_vld_pipe[RD_LAT-1];
    assign sch.pass_o       = r_pass_pipe[RD_LAT-1];
    assign sch.col_o        = r_col_pipe[RD_LAT-1];
    assign sch.row_end_o    = r_end_pipe[RD_LAT-1];
    assign sch.row_o        = r_row;
    // Gated by busy so the flag reads 0 while idle, even though the row counter rests at 0.
    assign sch.first_row_o  = (r_state != IDLE) && (r_row == '0);
    assign sch.busy_o       = (r_state != IDLE);
    assign sch.done_o       = w_done;
endmodule

// File: doc/png_line_sch.md
Name: png_line_sch

Overview:
- Row scheduler for the PNG filter line buffer: each image row is written into the buffer once, then read out three times (pass 0, 1, 2), one pass per filter-candidate evaluation.
- Sits between the pixel source and the filter datapath.
- Generates the buffer write/read strobes, column/row/pass indices, first-row and row/frame markers, and a downstream valid that honours backpressure.

Parameters:
- W_WD, 13, width of the row-width config and column counter; max row width 2^W_WD-1 pixels.
- H_WD, 13, width of the row-count config and row counter.
- RD_LAT, 1, buffer read latency in cycles from read strobe to data; legal values 1..2.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle frame start pulse
- abort_i  input  1  synchronous abort
- cfg_w_i  input  W_WD  pixels per row, 1..2^W_WD-1
- cfg_h_i  input  H_WD  rows per frame, 1..2^H_WD-1
- pix_val_i  input  1  upstream pixel valid
- pix_rdy_o  output  1  upstream ready (write accepted when pix_val_i && pix_rdy_o)
- buf_wr_val_o  output  1  line buffer write strobe
- buf_rd_val_o  output  1  line buffer read strobe
- dn_rdy_i  input  1  downstream ready
- dn_val_o  output  1  read data valid at filter input, aligned to buffer data
- pass_o  output  2  current read pass 0..2, aligned with dn_val_o
- col_o  output  W_WD  column of the current transfer, aligned with dn_val_o
- row_o  output  H_WD  current row index
- first_row_o  output  1  row_o==0 (filter uses zero "up" row)
- row_end_o  output  1  last column of pass 2, aligned with dn_val_o
- busy_o  output  1  state != IDLE
- done_o  output  1  one-cycle pulse after the last read of the frame

Behaviour:
- Reset: state IDLE; all counters 0; every output 0.
- Config: cfg_w_i and cfg_h_i are sampled into internal registers on the accepted start. Later input changes are ignored until the next start.
- FSM states: IDLE, LOAD, PASS, NEXT, DONE.
- IDLE:
  - start_i -> LOAD; row=0, col=0, pass=0.
  - start_i while busy is ignored.
- LOAD:
  - pix_rdy_o=1 only in LOAD.
  - Each accepted pixel asserts buf_wr_val_o in the same cycle and increments the column.
  - Accepting column w-1 sets column to 0 and moves to PASS next cycle.
- PASS:
  - buf_rd_val_o = (state==PASS) && dn_rdy_i && !abort_i.
  - Each read increments the column; column w-1 wraps to 0 and increments the pass.
  - Read at pass 2, column w-1 -> NEXT.
  - dn_rdy_i low stalls reads with no loss.
  - dn_val_o, pass_o, col_o and row_end_o are the read-cycle values delayed RD_LAT cycles through a shift pipe.
  - dn_rdy_i is sampled at read issue only; downstream must accept RD_LAT-delayed data unconditionally.
- NEXT:
  - If row==h-1 -> DONE; otherwise row+1, pass 0, -> LOAD.
  - NEXT is one cycle; first_row_o follows the registered row.
- DONE:
  - Waits until the read pipe drains (no dn_val_o in flight).
  - Then done_o=1 for one cycle and the next state is IDLE.
- abort_i: in any state, next cycle is IDLE with counters cleared and the read pipe flushed. No done_o, no further strobes. abort_i has priority over start_i.
- Boundaries:
  - cfg_w=1: each pass is one read; LOAD is one write.
  - cfg_h=1: first_row_o is high for the whole frame.
  - Column compare uses (col == w_r-1) at W_WD width. No counter overflows for legal configs.
- Latency, unstalled, per row: w cycles LOAD + 3w cycles PASS + 1 cycle NEXT.
- The buffer sees exactly w writes and then 3w reads per row, matching its write-once/read-three-times row discipline.

Test Plan:
- w=4, h=2, pix_val_i and dn_rdy_i tied high, pulse start:
  - 4 writes, then 12 reads with pass_o sequence 0,0,0,0,1,1,1,1,2,2,2,2 and col_o cycling 0..3.
  - row_end_o on the 12th dn_val_o.
  - first_row_o=1 for row 0 only.
  - done_o pulse RD_LAT+1 cycles after the final read; total 33 cycles from start to the last read.
- w=1, h=3: 3 reads per row, row_o 0,1,2, exactly one done_o pulse.
- w=8, dn_rdy_i toggling 1,0,1,0 in PASS: buf_rd_val_o only in dn_rdy_i=1 cycles, 24 dn_val_o per row, col/pass sequence unchanged.
- pix_val_i gapped in LOAD: buf_wr_val_o follows pix_val_i; pix_rdy_o low in PASS and NEXT; second start_i during busy ignored.
- abort_i mid pass 1 of row 0 (w=4): next cycle busy_o=0, no dn_val_o after the pipe flush, no done_o; a fresh start then runs a full frame correctly.
- Reset asserted mid-LOAD: all outputs 0 immediately; after release, state IDLE and outputs stay 0 until start.
